// File: rtl/obi_data_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_data_responder
// Description : OBI data-bus responder used in the core testbench. It answers
//               the core's req/gnt/rvalid data interface with a byte-enabled
//               word RAM, a print register and an exit register. Grant stall,
//               response latency and the number of outstanding responses are
//               configurable so the LSU handshake can be stressed.
// Ports       : clk_i, rst_ni          clock, synchronous active-low reset
//               data_req_i/data_gnt_o  request / grant handshake
//               data_addr_i, data_we_i, data_be_i, data_wdata_i
//                                      request attributes (sampled at grant)
//               data_rvalid_o/rdata_o  in-order response, rdata 0 when idle
//               print_valid_o/char_o   one-cycle pulse per print write
//               exit_valid_o/value_o   sticky exit flag and first exit value
//               err_cnt_o              saturating count of unmapped accesses
// Revision    : 1.0 - initial release
// ============================================================================
module obi_data_responder #(
    parameter int          RAM_ADDR_WIDTH  = 12,
    parameter int          GNT_STALL       = 0,
    parameter int          RVALID_DELAY    = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] PRINT_ADDR      = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        print_valid_o,
    output logic [7:0]  print_char_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic [15:0] err_cnt_o
);

    localparam int c_ram_words  = 2 ** (RAM_ADDR_WIDTH - 2);
    // Storage is always sized for the largest legal depth so the 2-bit
    // pointers index it exactly; only MAX_OUTSTANDING slots are ever used.
    localparam int c_fifo_slots = 4;

    logic [31:0] r_ram        [c_ram_words];
    logic [31:0] r_fifo_rdata [c_fifo_slots];
    logic [3:0]  r_fifo_timer [c_fifo_slots];
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_count;
    logic [31:0] r_stall_cnt;

    logic                      w_pop;
    logic                      w_slot_free;
    logic                      w_accept;
    logic                      w_ram_hit;
    logic                      w_print_hit;
    logic                      w_exit_hit;
    logic                      w_unmapped;
    logic [RAM_ADDR_WIDTH-3:0] w_word;
    logic [31:0]               w_push_rdata;
    logic [1:0]                w_rd_ptr_nxt;
    logic [1:0]                w_wr_ptr_nxt;

    // Head leaves the FIFO in the cycle its timer would hit zero; this is
    // what makes the first rvalid land exactly RVALID_DELAY cycles after grant.
    assign w_pop        = (r_count != 3'd0) && (r_fifo_timer[r_rd_ptr] <= 4'd1);
    assign w_slot_free  = (r_count < 3'(MAX_OUTSTANDING)) || w_pop;
    assign data_gnt_o   = data_req_i && (r_stall_cnt == 32'(GNT_STALL)) && w_slot_free;
    assign w_accept     = data_req_i && data_gnt_o;

    assign data_rvalid_o = w_pop;
    assign data_rdata_o  = w_pop ? r_fifo_rdata[r_rd_ptr] : 32'h0;

    assign w_rd_ptr_nxt = (r_rd_ptr == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : r_rd_ptr + 2'd1;
    assign w_wr_ptr_nxt = (r_wr_ptr == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : r_wr_ptr + 2'd1;

    // Address decode: RAM takes precedence; peripherals are write-only, so a
    // read of their addresses falls through to the unmapped path.
    assign w_ram_hit    = (data_addr_i[31:RAM_ADDR_WIDTH] == '0);
    assign w_word       = data_addr_i[RAM_ADDR_WIDTH-1:2];
    assign w_print_hit  = !w_ram_hit && data_we_i && (data_addr_i == PRINT_ADDR);
    assign w_exit_hit   = !w_ram_hit && data_we_i && (data_addr_i == EXIT_ADDR);
    assign w_unmapped   = !w_ram_hit && !w_print_hit && !w_exit_hit;
    assign w_push_rdata = (w_ram_hit && !data_we_i) ? r_ram[w_word] : 32'h0;

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_accept && w_ram_hit && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    r_ram[w_word][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_cnt   <= 32'd0;
            r_rd_ptr      <= 2'd0;
            r_wr_ptr      <= 2'd0;
            r_count       <= 3'd0;
            print_valid_o <= 1'b0;
            print_char_o  <= 8'h0;
            exit_valid_o  <= 1'b0;
            exit_value_o  <= 32'h0;
            err_cnt_o     <= 16'h0;
            for (int i = 0; i < c_fifo_slots; i++) begin
                r_fifo_rdata[i] <= 32'h0;
                r_fifo_timer[i] <= 4'd0;
            end
        end else begin
            if (!data_req_i || data_gnt_o) begin
                r_stall_cnt <= 32'd0;
            end else if (r_stall_cnt < 32'(GNT_STALL)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end

            for (int i = 0; i < c_fifo_slots; i++) begin
                if (r_fifo_timer[i] != 4'd0) begin
                    r_fifo_timer[i] <= r_fifo_timer[i] - 4'd1;
                end
            end

            // The push overrides the decrement above for the slot it fills;
            // when full with a simultaneous pop, that slot is the one leaving.
            if (w_accept) begin
                r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
                r_fifo_timer[r_wr_ptr] <= 4'(RVALID_DELAY);
                r_wr_ptr               <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            print_valid_o <= w_accept && w_print_hit;
            if (w_accept && w_print_hit) begin
                print_char_o <= data_wdata_i[7:0];
            end

            if (w_accept && w_exit_hit && !exit_valid_o) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= data_wdata_i;
            end

            if (w_accept && w_unmapped && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // An initiator must hold a pending request, unchanged, until granted.
    a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> data_req_i)
        else $error("obi_data_responder: data_req_i dropped before grant");

    a_attr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> ($stable(data_addr_i) && $stable(data_we_i)
                                         && $stable(data_be_i) && $stable(data_wdata_i)))
        else $error("obi_data_responder: request attributes changed before grant");
`endif

endmodule
`default_nettype wire

// File: doc/obi_data_responder.md
Name: obi_data_responder

Overview:
- Synthesizable-style OBI data-bus responder for the core testbench. It answers the core's data_req/gnt/rvalid initiator interface.
- Contains a byte-enabled word RAM, a print peripheral and an exit peripheral.
- Supports configurable grant stall, response latency and bounded outstanding transactions, so the core's LSU handshake can be stressed.
- Sits between the core data port and the testbench top, replacing the fixed-latency data side of the memory model.

Parameters:
- RAM_ADDR_WIDTH, 12: byte-address width of the internal RAM (2^RAM_ADDR_WIDTH bytes, word organised).
- GNT_STALL, 0: cycles data_gnt_o is withheld after data_req_i first rises (0 = grant in same cycle).
- RVALID_DELAY, 1: cycles from grant to data_rvalid_o (legal 1..8).
- MAX_OUTSTANDING, 2: response FIFO depth (legal 1..4).
- PRINT_ADDR, 32'h1000_0000: write-only character output register.
- EXIT_ADDR, 32'h2000_0004: write-only exit register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- data_req_i  in  1  OBI request
- data_gnt_o  out  1  OBI grant
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  read data (0 for writes)
- print_valid_o  out  1  one-cycle pulse on a print write
- print_char_o  out  8  wdata[7:0] of the print write
- exit_valid_o  out  1  sticky, set by a write to EXIT_ADDR
- exit_value_o  out  32  wdata of the first exit write
- err_cnt_o  out  16  count of accesses to unmapped addresses, saturating

Behaviour:
- Reset:
  - Synchronous on rising clk_i while rst_ni = 0.
  - All outputs go to 0; stall counter and FIFO pointers/count go to 0. Outstanding responses are dropped.
  - RAM contents are not reset.
  - Reset mid-transaction discards pending responses; no rvalid follows.
- Grant:
  - data_gnt_o = data_req_i && (stall_cnt == GNT_STALL) && slot_free. It is combinational from data_req_i.
  - stall_cnt increments each cycle data_req_i=1 and gnt=0 (saturating at GNT_STALL). It clears to 0 on grant or when data_req_i=0.
  - slot_free = (count < MAX_OUTSTANDING) || pop_this_cycle. A simultaneous pop frees the slot in the same cycle.
  - Address and attributes are sampled only in the grant cycle.
- Accept (req && gnt):
  - RAM hit when data_addr_i[31:RAM_ADDR_WIDTH] == 0.
    - Write: update bytes with be=1 at word addr[RAM_ADDR_WIDTH-1:2]; addr[1:0] ignored.
    - Read: capture the full word at accept time. be does not mask read data.
  - Write to PRINT_ADDR: print_valid_o=1 next cycle for one cycle, print_char_o=wdata[7:0].
  - Write to EXIT_ADDR: exit_valid_o=1 next cycle. exit_value_o is latched only if exit_valid_o was 0; later exit writes are ignored.
  - Any other address, including reads of PRINT_ADDR/EXIT_ADDR: write dropped, read returns 32'h0, err_cnt_o += 1 (saturating at 16'hFFFF).
  - Every accepted transaction pushes {rdata, timer=RVALID_DELAY} into the FIFO.
- Response:
  - The FIFO decrements every entry's timer each cycle (floor 0).
  - When the head timer would reach 0 this cycle, data_rvalid_o=1 and data_rdata_o=head rdata, and the head pops. The first rvalid is exactly RVALID_DELAY cycles after the grant edge.
  - Responses are strictly in grant order. There is no back-pressure (OBI without rready).
  - At most one rvalid per cycle. Back-to-back grants produce back-to-back rvalids.
  - data_rdata_o = 0 when data_rvalid_o = 0.
- Read-after-write: a read granted the cycle after a write to the same word returns the new data.
- Push and pop in the same cycle leave count unchanged. Count never exceeds MAX_OUTSTANDING, and FIFO pointers wrap modulo MAX_OUTSTANDING.
- Simulation-only assertions (not synthesized):
  - data_req_i low while a request is ungranted.
  - Attribute change while a request is ungranted.

Test Plan:
- GNT_STALL=0, RVALID_DELAY=1: write 0xCAFEBABE be=4'hF to 0x100, then read 0x100 -> gnt in the same cycle each time; read rvalid 1 cycle after its grant with rdata=0xCAFEBABE.
- Byte enables: write 0x11223344 be=4'hF, then 0xAABBCCDD be=4'b0101 to 0x40, read 0x40 -> rdata=0x11BB33DD.
- GNT_STALL=3: req held from cycle 0 -> gnt at cycle 3, stall_cnt back to 0; dropping req at cycle 2 restarts the count.
- MAX_OUTSTANDING=2, RVALID_DELAY=4, continuous reads to 0x0, 0x4, 0x8:
  - grants at cycles 0 and 1; third gnt at cycle 4, coinciding with the first pop;
  - three rvalids in order at cycles 4, 5, 8.
- Peripherals:
  - write 0x41 to PRINT_ADDR -> print_valid_o pulse with print_char_o=0x41;
  - write 7 then 9 to EXIT_ADDR -> exit_valid_o=1, exit_value_o=7;
  - read 0x3000_0000 -> rdata=0, err_cnt_o=1.
- Reset with 2 responses outstanding -> no rvalid afterwards; all outputs 0 the cycle after reset; RAM data written before reset still reads back.
